// File: rtl/cpu_pkg.sv
// Shared CPU constants: opcodes, bubble instruction, reset PC and fetch state encodings.
package cpu_pkg;

    localparam logic [3:0]  OP_NOP           = 4'b1110;
    localparam logic [3:0]  OP_HALT          = 4'b1111;
    localparam logic [15:0] NOP_INSTR        = {OP_NOP, 12'h000};
    localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;

    // Fetch FSM encodings
    localparam logic [1:0] ST_FETCH   = 2'd0;
    localparam logic [1:0] ST_DISCARD = 2'd1;
    localparam logic [1:0] ST_HALTED  = 2'd2;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {instr, pc} holding buffer for a response that arrives while decode is stalled.
module fetch_skid_buf (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        drain,
    input  logic        clear,
    input  logic [15:0] in_instr,
    input  logic [15:0] in_pc,
    output logic        full,
    output logic [15:0] out_instr,
    output logic [15:0] out_pc
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full      <= 1'b0;
            out_instr <= 16'h0000;
            out_pc    <= 16'h0000;
        end else if (clear) begin
            full <= 1'b0;
        end else if (load) begin
            full      <= 1'b1;
            out_instr <= in_instr;
            out_pc    <= in_pc;
        end else if (drain) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: single outstanding memory request, skid buffer for stalls,
// redirect with in-flight response discard, and a sticky halt.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [15:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [15:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_rdata,
    input  logic        imem_valid,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_target,
    input  logic        halt,
    output logic [15:0] ifid_instr,
    output logic [15:0] ifid_pc,
    output logic        ifid_valid,
    output logic [3:0]  opcode
);

    logic [1:0]  state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] req_addr_q, req_addr_d;
    logic [15:0] ifid_instr_q, ifid_instr_d;
    logic [15:0] ifid_pc_q, ifid_pc_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic        skid_load, skid_drain, skid_clear, skid_full;
    logic [15:0] skid_instr, skid_pc;

    fetch_skid_buf u_skid (
        .clk       (clk),
        .rst       (rst),
        .load      (skid_load),
        .drain     (skid_drain),
        .clear     (skid_clear),
        .in_instr  (imem_rdata),
        .in_pc     (req_addr_q),
        .full      (skid_full),
        .out_instr (skid_instr),
        .out_pc    (skid_pc)
    );

    // req_addr differs from pc only in DISCARD, where the old address must stay on the bus.
    assign imem_req   = !rst && (((state_q == ST_FETCH) && !skid_full) || (state_q == ST_DISCARD));
    assign imem_addr  = req_addr_q;
    assign ifid_instr = ifid_instr_q;
    assign ifid_pc    = ifid_pc_q;
    assign ifid_valid = ifid_valid_q;
    assign opcode     = ifid_instr_q[15:12];

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_addr_d   = req_addr_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_valid_d = ifid_valid_q;
        skid_load    = 1'b0;
        skid_drain   = 1'b0;
        skid_clear   = 1'b0;
        if (state_q != ST_HALTED) begin
            if (redirect) begin
                pc_d         = redirect_target;
                ifid_instr_d = NOP_INSTR;
                ifid_valid_d = 1'b0;
                skid_clear   = 1'b1;
                if (imem_req && !imem_valid) begin
                    state_d = ST_DISCARD;
                end else begin
                    state_d    = ST_FETCH;
                    req_addr_d = redirect_target;
                end
            end else if (halt) begin
                state_d      = ST_HALTED;
                ifid_instr_d = NOP_INSTR;
                ifid_valid_d = 1'b0;
                skid_clear   = 1'b1;
            end else if (state_q == ST_DISCARD) begin
                if (imem_valid) begin
                    state_d    = ST_FETCH;
                    req_addr_d = pc_q;
                end
            end else if (skid_full) begin
                if (!stall) begin
                    ifid_instr_d = skid_instr;
                    ifid_pc_d    = skid_pc;
                    ifid_valid_d = 1'b1;
                    skid_drain   = 1'b1;
                end
            end else if (imem_valid) begin
                pc_d       = pc_q + 16'd1;
                req_addr_d = pc_q + 16'd1;
                if (stall) begin
                    skid_load = 1'b1;
                end else begin
                    ifid_instr_d = imem_rdata;
                    ifid_pc_d    = req_addr_q;
                    ifid_valid_d = 1'b1;
                end
            end else if (!stall) begin
                // Nothing new to hand over: insert a bubble so decode never re-executes.
                ifid_instr_d = NOP_INSTR;
                ifid_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_FETCH;
            pc_q         <= RESET_PC;
            req_addr_q   <= RESET_PC;
            ifid_instr_q <= NOP_INSTR;
            ifid_pc_q    <= RESET_PC;
            ifid_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_addr_q   <= req_addr_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_valid_q <= ifid_valid_d;
        end
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL have one clock and asynchronous active-high reset; reset is the only asynchronous input.
REQ-002 Parameter RESET_PC, 16'h0000, PC value loaded at reset.
REQ-003 Parameter NOP_INSTR, 16'hE000, bubble instruction (opcode 4'b1110).
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 imem_req  out  1  instruction-memory request.
REQ-007 imem_addr  out  16  word address of the request, stable while imem_req=1 until imem_valid.
REQ-008 imem_rdata  in  16  returned instruction, valid when imem_valid=1.
REQ-009 imem_valid  in  1  single-cycle response strobe, exactly one per accepted request, latency 1..N cycles.
REQ-010 stall  in  1  hold IF/ID register and PC (from hazard unit).
REQ-011 redirect  in  1  taken branch/jump from execute.
REQ-012 redirect_target  in  16  new PC when redirect=1.
REQ-013 halt  in  1  halt decoded in ID (already gated by stall/flush in decode).
REQ-014 ifid_instr  out  16  registered instruction to decode.
REQ-015 ifid_pc  out  16  registered PC of ifid_instr.
REQ-016 ifid_valid  out  1  ifid_instr is a real fetched instruction.
REQ-017 opcode  out  4  ifid_instr[15:12], combinational, drives decode opcode.

Function
REQ-018 States SHALL be FETCH, DISCARD, HALTED; one request outstanding at most.
REQ-019 FETCH: imem_req=1 and imem_addr=req_addr unless skid buffer full; a new request issues the cycle after the previous response.
REQ-020 FETCH, imem_valid=1, stall=0, skid empty: IF/ID <= {imem_rdata, req_addr, valid=1}; pc <= pc+1 (16-bit wrap, 16'hFFFF -> 16'h0000).
REQ-021 FETCH, imem_valid=1, stall=1: response SHALL be captured in the one-entry skid buffer; imem_req deasserts until the buffer drains.
REQ-022 stall=0 with skid full: IF/ID <= skid contents the same edge, skid empties, requests resume next cycle; zero instructions lost or duplicated.
REQ-023 stall=1 and no other event: IF/ID, pc, skid unchanged.
REQ-024 redirect=1: pc <= redirect_target; IF/ID <= {NOP_INSTR, ifid_pc, valid=0}; skid cleared; if a request is outstanding and imem_valid=0, state -> DISCARD, else state FETCH.
REQ-025 DISCARD: imem_req=1 holding the old address; next imem_valid is dropped; then -> FETCH issuing at redirect_target.
REQ-026 halt=1 (redirect=0): state -> HALTED, IF/ID <= NOP with valid=0, pc frozen; HALTED holds imem_req=0, ignores imem_valid, exits only on rst.
REQ-027 Priority per edge: rst > redirect > halt > stall > normal fetch.
REQ-028 redirect and imem_valid same cycle: response dropped, next request at target next cycle, state FETCH.
REQ-029 Fetch-to-IF/ID latency: one clock after imem_valid when not stalled.

Reset
REQ-030 rst SHALL force pc=req_addr=RESET_PC, state=FETCH, ifid_instr=NOP_INSTR, ifid_pc=RESET_PC, ifid_valid=0, skid empty, imem_req=0 asynchronously.
REQ-031 First request SHALL issue the first cycle after rst deasserts; a response arriving for a pre-reset request SHALL be dropped (DISCARD entered if rst hit mid-request is not tracked: memory model resets with rst).

Structure
REQ-032 Shared package cpu_pkg SHALL hold OP_NOP=4'b1110, OP_HALT=4'b1111, NOP_INSTR, RESET_PC default, fetch state enum.
REQ-033 One sub-module fetch_skid_buf (one-entry {instr, pc} buffer, load/drain/clear) SHALL be instantiated; the rest stays flat.

Verification
REQ-034 Reset, memory latency 1, no stall: addresses 0,1,2,3 requested; ifid_pc 0,1,2,3 each with ifid_valid=1, opcode=ifid_instr[15:12].
REQ-035 Latency 3, stall asserted during a response for 4 cycles: response held in skid, imem_req=0, on release IF/ID shows it once, next address = previous+1.
REQ-036 Redirect to 16'h0040 while request to 16'h0005 outstanding: response for 5 dropped, next request 16'h0040, ifid_valid=0 for the bubble.
REQ-037 halt=1 at PC 7: next cycle ifid_valid=0, ifid_instr=16'hE000, imem_req stays 0 for 20 cycles despite imem_valid pulses; rst restores fetch at RESET_PC.
REQ-038 redirect+halt+stall same cycle to 16'h0100: redirect wins, state FETCH, next request 16'h0100; PC 16'hFFFF fetch then next address 16'h0000.
